// File: rtl/adder_ctrl_pkg.sv
// Shared control definitions for the chunked add/sub sequencer:
// FSM state encodings, chunk-count derivation and a parameter sanity check.
`ifndef ADDER_CTRL_PKG_SV
`define ADDER_CTRL_PKG_SV

// Elaboration-time guard: the operand width must split into whole chunks.
`define ADDER_CTRL_CHECK_DIV(W, C) if (((W) % (C)) != 0) begin : g_chunk_check $error("WIDTH must be a multiple of CHUNK"); end

package adder_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Number of slice passes per operation.
    function automatic int nch_of(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Chunk index width; at least one bit so NCH==1 still has a legal register.
    function automatic int idx_width(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

`endif

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple-carry slice built from full-adder cells,
// carry chain runs from bit 0 up to the MSB.
module chunk_adder #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             c_in,
    output logic [CHUNK-1:0] s,
    output logic             c_out
);

    logic [CHUNK:0] c;

    assign c[0] = c_in;

    // One full-adder cell per bit position.
    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign c_out = c[CHUNK];

endmodule

// File: rtl/chunked_adder_seq.sv
// Multi-cycle add/sub sequencer: one CHUNK-bit slice reused WIDTH/CHUNK
// times, linked by a registered carry. Valid/ready on both sides, one op
// in flight.
module chunked_adder_seq
    import adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op_sub,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NCH = nch_of(WIDTH, CHUNK);
    localparam int IW  = idx_width(NCH);
    localparam logic [IW-1:0] LAST = IW'(NCH - 1);

    `ADDER_CTRL_CHECK_DIV(WIDTH, CHUNK)

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [31:0]      base;
    logic [CHUNK-1:0] sl_x, sl_y, sl_s;
    logic             sl_co;

    assign base = 32'(idx_q) * 32'(CHUNK);
    assign sl_x = a_q[base +: CHUNK];
    assign sl_y = b_q[base +: CHUNK];

    chunk_adder #(
        .CHUNK(CHUNK)
    ) u_slice (
        .x    (sl_x),
        .y    (sl_y),
        .c_in (carry_q),
        .s    (sl_s),
        .c_out(sl_co)
    );

    // Next-state logic: operand capture, per-chunk accumulation, result handshake.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (start_valid) begin
                    a_d     = a;
                    b_d     = op_sub ? ~b : b;
                    carry_d = op_sub ? 1'b1 : cin;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sum_d[base +: CHUNK] = sl_s;
                carry_d = sl_co;
                if (idx_q == LAST) begin
                    // Final chunk's top bit is the result MSB.
                    cout_d  = sl_co;
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sl_s[CHUNK-1] != a_q[WIDTH-1]);
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign start_ready = (state_q == ST_IDLE);
    assign res_valid   = (state_q == ST_DONE);
    assign busy        = (state_q != ST_IDLE);
    assign sum         = sum_q;
    assign cout        = cout_q;
    assign ovf         = ovf_q;

endmodule
